// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the approximate multiplier datapath:
//   - FSM state encoding of the partial-product sequencer
//   - select codes driven to the bit_mask_sel stage
//   - width of the multiplier bit-pair index
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_X    = 2'b01;
    localparam logic [1:0] SEL_XY   = 2'b11;

    // Pair index width; covers operands up to 512 bits (256 pairs).
    localparam int PAIR_IDX_W = 8;

endpackage

// File: rtl/pp_pair_decode.sv
// pp_pair_decode
// Combinational decode of one multiplier bit-pair into the select code and
// shifted multiplicand operands for bit_mask_sel.
// Ports:
//   pair  in  2           multiplier bits {b[2i+1], b[2i]}
//   idx   in  PAIR_IDX_W  pair index i
//   a_ext in  WIDTH       multiplicand, zero-extended
//   sel   out 2           select code
//   x     out WIDTH       first operand
//   y     out WIDTH       second operand (only used for pair 11)
module pp_pair_decode
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]            pair,
    input  logic [PAIR_IDX_W-1:0] idx,
    input  logic [WIDTH-1:0]      a_ext,
    output logic [1:0]            sel,
    output logic [WIDTH-1:0]      x,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        sel = SEL_ZERO;
        x   = '0;
        y   = '0;
        case (pair)
            2'b01: begin
                sel = SEL_X;
                x   = a_ext << {idx, 1'b0};
            end
            2'b10: begin
                sel = SEL_X;
                x   = a_ext << {idx, 1'b1};
            end
            2'b11: begin
                // 3*A*4^i is delivered as A<<2i plus A<<(2i+1)
                sel = SEL_XY;
                x   = a_ext << {idx, 1'b0};
                y   = a_ext << {idx, 1'b1};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pp_seq_accum.sv
// pp_seq_accum
// Sequential partial-product sequencer and accumulator. Scans the multiplier
// two bits per cycle, drives sel/x/y to bit_mask_sel, and accumulates its
// combinational result r into the product.
// Optional feature: define APPROX_TRUNC_EN to skip the low TRUNC_PAIRS
// multiplier bit-pairs (fewer RUN cycles, truncated product).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready, a, b  operand handshake (unsigned N-bit operands)
//   sel, x, y              registered operands to bit_mask_sel
//   r                      combinational result from bit_mask_sel
//   out_valid/out_ready, product  product handshake (WIDTH bits)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one multiplier pair per cycle, acc += r
// DONE  | product presented, held until out_ready
module pp_seq_accum
    import approx_mult_pkg::*;
#(
    parameter int N           = 8,
    parameter int WIDTH       = 2 * N,
    parameter int TRUNC_PAIRS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    localparam int NPAIRS = N / 2;
`ifdef APPROX_TRUNC_EN
    localparam int START = TRUNC_PAIRS;
`else
    // Truncation depth has no effect in the exact build.
    localparam int START = 0 * TRUNC_PAIRS;
`endif
    localparam int P = NPAIRS - START;
    localparam logic [PAIR_IDX_W-1:0] START_IDX = PAIR_IDX_W'(START);
    localparam logic [PAIR_IDX_W-1:0] LAST_IDX  = PAIR_IDX_W'(NPAIRS - 1);

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      a_reg, a_nxt, acc, acc_nxt;
    logic [N-1:0]          b_reg, b_nxt;
    logic [PAIR_IDX_W-1:0] idx, idx_nxt;
    logic [1:0]            sel_nxt;
    logic [WIDTH-1:0]      x_nxt, y_nxt;

    logic                  load_dec;
    logic [N-1:0]          dec_b;
    logic [WIDTH-1:0]      dec_a;
    logic [PAIR_IDX_W-1:0] dec_idx;
    logic [1:0]            dec_pair, dec_sel;
    logic [WIDTH-1:0]      dec_x, dec_y;

    assign dec_pair = 2'(dec_b >> {dec_idx, 1'b0});

    pp_pair_decode #(.WIDTH(WIDTH)) u_decode (
        .pair  (dec_pair),
        .idx   (dec_idx),
        .a_ext (dec_a),
        .sel   (dec_sel),
        .x     (dec_x),
        .y     (dec_y)
    );

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    // acc only moves during RUN or on accept, so it holds through DONE.
    assign product   = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The decoder looks one pair ahead so sel/x/y are registered and line up
    // with the RUN cycle that accumulates their result.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        acc_nxt   = acc;
        idx_nxt   = idx;
        load_dec  = 1'b0;
        dec_a     = a_reg;
        dec_b     = b_reg;
        dec_idx   = idx + PAIR_IDX_W'(1);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt   = WIDTH'(a);
                    b_nxt   = b;
                    acc_nxt = '0;
                    idx_nxt = START_IDX;
                    dec_a   = WIDTH'(a);
                    dec_b   = b;
                    dec_idx = START_IDX;
                    if (P == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        load_dec  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_nxt = acc + r;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt  = idx + PAIR_IDX_W'(1);
                    load_dec = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        sel_nxt = load_dec ? dec_sel : SEL_ZERO;
        x_nxt   = load_dec ? dec_x : '0;
        y_nxt   = load_dec ? dec_y : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
            sel   <= SEL_ZERO;
            x     <= '0;
            y     <= '0;
        end else begin
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            sel   <= sel_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
        end
    end

endmodule

// File: tb/tb_pp_seq_accum.sv
// tb_pp_seq_accum
// Self-checking bench for pp_seq_accum (N=8, WIDTH=16, TRUNC_PAIRS=1).
// Models bit_mask_sel as r = 0 / x / x+y and checks every cycle against a
// product-level model; directed cases pin literal products and latencies.
// Honours APPROX_TRUNC_EN when defined for the whole compile.
module tb_pp_seq_accum;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int TP = 1;
`ifdef APPROX_TRUNC_EN
    localparam int START = TP;
`else
    localparam int START = 0;
`endif
    localparam int P = N / 2 - START;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          in_ready, out_valid;
    logic [1:0]    sel;
    logic [W-1:0]  x, y, r, product;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pp_seq_accum #(.N(N), .WIDTH(W), .TRUNC_PAIRS(TP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .x         (x),
        .y         (y),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Exact bit_mask_sel stand-in.
    always_comb begin
        case (sel)
            2'b01:   r = x;
            2'b11:   r = x + y;
            default: r = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] golden(input logic [N-1:0] ga, input logic [N-1:0] gb);
        logic [N-1:0] bm;
        bm = (gb >> (2 * START)) << (2 * START);
        return W'(ga) * W'(bm);
    endfunction

    function automatic void pair_exp(input logic [N-1:0] pa, input logic [N-1:0] pb, input int i,
                                     output logic [1:0] es, output logic [W-1:0] ex,
                                     output logic [W-1:0] ey);
        logic [1:0]   p;
        logic [W-1:0] ae;
        p  = 2'(pb >> (2 * i));
        ae = W'(pa);
        es = 2'b00;
        ex = '0;
        ey = '0;
        case (p)
            2'b01: begin es = 2'b01; ex = ae << (2 * i); end
            2'b10: begin es = 2'b01; ex = ae << (2 * i + 1); end
            2'b11: begin es = 2'b11; ex = ae << (2 * i); ey = ae << (2 * i + 1); end
            default: ;
        endcase
    endfunction

    // Cycle-by-cycle model: accept, P RUN cycles, then DONE until out_ready.
    bit           busy = 1'b0;
    int           k = 0;
    int           handoffs = 0;
    logic [N-1:0] ma, mb;
    logic [1:0]   es;
    logic [W-1:0] ex, ey;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_product", product, 0);
            chk("rst_sel", sel, 0);
            chk("rst_x", x, 0);
            chk("rst_y", y, 0);
        end else if (busy) begin
            k++;
            if (k <= P) begin
                pair_exp(ma, mb, START + k - 1, es, ex, ey);
                chk("run_sel", sel, es);
                chk("run_x", x, ex);
                chk("run_y", y, ey);
                chk("run_out_valid", out_valid, 0);
                chk("run_in_ready", in_ready, 0);
            end else begin
                chk("done_out_valid", out_valid, 1);
                chk("done_product", product, golden(ma, mb));
                chk("done_in_ready", in_ready, 0);
                chk("done_sel", sel, 0);
                if (out_ready) begin
                    busy = 1'b0;
                    handoffs++;
                end
            end
        end else begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_sel", sel, 0);
            chk("idle_x", x, 0);
            chk("idle_y", y, 0);
            if (in_valid) begin
                busy = 1'b1;
                k    = 0;
                ma   = a;
                mb   = b;
            end
        end
    end

    logic [1:0] sel_log [0:7];

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input int hold,
                          output logic [W-1:0] prod, output int lat);
        int n;
        logic [W-1:0] held;
        prod = '0;
        lat  = 0;
        @(posedge clk); #1;
        a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 8) sel_log[lat-1] = sel;
        end while (!out_valid && lat < 40);
        if (!out_valid) begin
            chk("out_valid_timeout", out_valid, 1);
            return;
        end
        prod = product;
        held = product;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = N'(h + 3); b = N'(h + 5);
            @(negedge clk);
            chk("bp_product", product, held);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [W-1:0] prod;
    int           lat;
    int           h0;

    initial begin
        rst_n = 1'b0;
        #1;
        chk("init_in_ready", in_ready, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_product", product, 0);
        chk("init_sel", sel, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef APPROX_TRUNC_EN
        run_op(8'd13, 8'd11, 0, prod, lat);
        chk("p_13x11", prod, 104);
        chk("lat_13x11", lat, 4);
        chk("sel0_13x11", sel_log[0], 1);
        chk("sel1_13x11", sel_log[1], 0);
        chk("sel2_13x11", sel_log[2], 0);
        run_op(8'd255, 8'd255, 0, prod, lat);
        chk("p_255x255", prod, 64260);
        run_op(8'd5, 8'd3, 0, prod, lat);
        chk("p_5x3", prod, 0);
        run_op(8'd5, 8'd7, 0, prod, lat);
        chk("p_5x7", prod, 20);
        chk("lat_5x7", lat, 4);
`else
        run_op(8'd13, 8'd11, 0, prod, lat);
        chk("p_13x11", prod, 143);
        chk("lat_13x11", lat, 5);
        chk("sel0_13x11", sel_log[0], 3);
        chk("sel1_13x11", sel_log[1], 1);
        chk("sel2_13x11", sel_log[2], 0);
        chk("sel3_13x11", sel_log[3], 0);
        run_op(8'd255, 8'd255, 0, prod, lat);
        chk("p_255x255", prod, 65025);
        chk("lat_255x255", lat, 5);
`endif
        run_op(8'd0, 8'd200, 0, prod, lat);
        chk("p_0x200", prod, 0);
        run_op(8'd200, 8'd0, 0, prod, lat);
        chk("p_200x0", prod, 0);
        for (int i = 0; i < P; i++) chk("sel_zero_b0", sel_log[i], 0);

        run_op(8'd9, 8'd10, 3, prod, lat);
`ifdef APPROX_TRUNC_EN
        chk("p_bp_9x10", prod, 72);
`else
        chk("p_bp_9x10", prod, 90);
`endif

        // Reset in the second RUN cycle aborts the operation.
        @(posedge clk); #1;
        a = 8'd100; b = 8'd150; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_test_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sel", sel, 0);
        chk("abort_x", x, 0);
        chk("abort_y", y, 0);
        chk("abort_product", product, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'd6, 8'd7, 0, prod, lat);
`ifdef APPROX_TRUNC_EN
        chk("p_6x7", prod, 24);
`else
        chk("p_6x7", prod, 42);
`endif

        // Random back-to-back traffic with random backpressure.
        h0 = handoffs;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            a         = N'($urandom);
            b         = N'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_out_valid", out_valid, 0);
        chk("rand_handoffs", 32'(handoffs > h0 + 10), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
